// File: rtl/sb_tx_multi_ch_fsm_if.sv
// Handshake and status bundle between the sideband TX scheduler, its source FIFOs
// and the shared serializer. The scheduler connects through the master modport.
interface sb_tx_multi_ch_fsm_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int CH_W  = $clog2(N_CH > 1 ? N_CH : 2)
);
    logic [N_CH-1:0]  i_empty;
    logic             i_read_enable_sampled;
    logic             i_dont_send_zeros;
    logic             i_ser_done;
    logic             i_packet_finished;
    logic [N_CH-1:0]  o_read_enable;
    logic [CH_W-1:0]  o_ch_sel;
    logic             o_clk_en;
    logic             o_busy;
    logic             o_timeout_err;
    logic [CNT_W-1:0] o_drop_cnt;

    modport master (
        input  i_empty,
        input  i_read_enable_sampled,
        input  i_dont_send_zeros,
        input  i_ser_done,
        input  i_packet_finished,
        output o_read_enable,
        output o_ch_sel,
        output o_clk_en,
        output o_busy,
        output o_timeout_err,
        output o_drop_cnt
    );

    modport slave (
        output i_empty,
        output i_read_enable_sampled,
        output i_dont_send_zeros,
        output i_ser_done,
        output i_packet_finished,
        input  o_read_enable,
        input  o_ch_sel,
        input  o_clk_en,
        input  o_busy,
        input  o_timeout_err,
        input  o_drop_cnt
    );
endinterface

// File: rtl/sb_tx_multi_ch_fsm.sv
// Round-robin sideband TX scheduler: grants one source FIFO at a time, runs the read
// handshake, gates the serializer clock per packet and enforces an inter-packet gap.
module sb_tx_multi_ch_fsm #(
    parameter int N_CH       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8,
    parameter int CH_W       = $clog2(N_CH > 1 ? N_CH : 2)
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    sb_tx_multi_ch_fsm_if.master bus
);

    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SENDING,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [N_CH-1:0]  rd_en_q, rd_en_d;
    logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic             to_err_q, to_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             req_any;
    logic [CH_W-1:0]  req_ch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + 1'b1;
    endfunction

    function automatic logic [N_CH-1:0] one_hot(input logic [CH_W-1:0] ch);
        logic [N_CH-1:0] res;
        for (int i = 0; i < N_CH; i++) begin
            res[i] = (CH_W'(i) == ch);
        end
        return res;
    endfunction

    function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
    endfunction

    // First non-empty channel at or above the round-robin pointer, wrapping to 0.
    always_comb begin
        req_any = 1'b0;
        req_ch  = rr_q;
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % N_CH;
            if (!req_any && !bus.i_empty[idx]) begin
                req_any = 1'b1;
                req_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_en_d    = '0;
        ch_sel_d   = ch_sel_q;
        rr_d       = rr_q;
        clk_en_d   = 1'b0;
        to_err_d   = 1'b0;
        drop_cnt_d = drop_cnt_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d  = FETCH;
                    rd_en_d  = one_hot(req_ch);
                    ch_sel_d = req_ch;
                    rr_d     = next_ptr(req_ch);
                    to_cnt_d = '0;
                end
            end

            // An ack on the expiry cycle takes priority over the timeout.
            FETCH: begin
                if (bus.i_read_enable_sampled) begin
                    if (bus.i_dont_send_zeros) begin
                        state_d    = IDLE;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else begin
                        state_d  = SENDING;
                        clk_en_d = 1'b1;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    to_err_d = 1'b1;
                end else begin
                    rd_en_d  = rd_en_q;
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            SENDING: begin
                if (bus.i_ser_done) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_W'(GAP_CYCLES);
                end else begin
                    clk_en_d = 1'b1;
                end
            end

            // The GAP state itself is the first idle cycle, so leave once the count is at or below one.
            GAP: begin
                if ((gap_cnt_q <= GAP_W'(1)) && !bus.i_packet_finished) begin
                    state_d = IDLE;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rd_en_q    <= '0;
            ch_sel_q   <= '0;
            rr_q       <= '0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            to_err_q   <= 1'b0;
            drop_cnt_q <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            ch_sel_q   <= ch_sel_d;
            rr_q       <= rr_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            to_err_q   <= to_err_d;
            drop_cnt_q <= drop_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.o_read_enable = rd_en_q;
    assign bus.o_ch_sel      = ch_sel_q;
    assign bus.o_clk_en      = clk_en_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_timeout_err = to_err_q;
    assign bus.o_drop_cnt    = drop_cnt_q;

    a_rd_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(rd_en_q));
    a_rd_vs_clk : assert property (@(posedge i_clk) disable iff (!i_rst_n) !(clk_en_q && (|rd_en_q)));
    a_clk_state : assert property (@(posedge i_clk) disable iff (!i_rst_n) clk_en_q |-> (state_q == SENDING));

endmodule

// File: doc/sb_tx_multi_ch_fsm.md
Name: sb_tx_multi_ch_fsm

Overview:
Parametrised sideband TX scheduler for N_CH source FIFOs feeding one shared serializer. It performs round-robin arbitration and a per-packet read handshake with the selected FIFO. It gates the serializer clock while a packet shifts out and enforces a programmable inter-packet gap. It also drops all-zero packets, times out stalled read handshakes, and counts dropped packets.

Parameters:
N_CH, 4, number of source FIFOs (1..16)
GAP_CYCLES, 2, minimum idle cycles after i_ser_done before the next arbitration (0 allowed)
TIMEOUT, 16, max cycles o_read_enable may wait for i_read_enable_sampled (>=2)
CNT_W, 8, width of drop counter
CH_W, $clog2(N_CH>1?N_CH:2), derived, channel index width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_empty  in  N_CH  per-channel FIFO empty flags
i_read_enable_sampled  in  1  ack: selected FIFO has sampled read enable
i_dont_send_zeros  in  1  valid with ack: read data is all zeros, drop packet
i_ser_done  in  1  serializer finished current packet
i_packet_finished  in  1  downstream still closing previous packet; blocks exit from GAP
o_read_enable  out  N_CH  one-hot read enable to granted FIFO
o_ch_sel  out  CH_W  granted channel index (mux select for serializer data)
o_clk_en  out  1  serializer clock enable
o_busy  out  1  state != IDLE
o_timeout_err  out  1  one-cycle pulse on handshake timeout
o_drop_cnt  out  CNT_W  saturating count of zero packets dropped

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all outputs 0, rr pointer 0, gap/timeout counters 0. Mid-operation reset aborts immediately; no partial pulses survive.
- All outputs registered. States: IDLE, FETCH, SENDING, GAP.
- IDLE: if any ~i_empty[k], grant the first non-empty channel searching from rr pointer upward with wrap (N_CH-1 -> 0). Next cycle: state FETCH, o_read_enable = one-hot(k), o_ch_sel = k, rr pointer = k+1 mod N_CH, timeout counter cleared. With no request, stay IDLE and hold o_ch_sel.
- FETCH: hold o_read_enable until i_read_enable_sampled.
  - Ack with i_dont_send_zeros=1: next cycle o_read_enable=0, state IDLE, o_drop_cnt+1 (saturate at all-ones).
  - Ack with i_dont_send_zeros=0: next cycle o_read_enable=0, state SENDING, o_clk_en=1.
  - No ack after TIMEOUT cycles in FETCH: next cycle o_read_enable=0, o_timeout_err=1 for one cycle, state IDLE. Ack on the same cycle as expiry wins over timeout.
  - i_dont_send_zeros without ack is ignored.
- SENDING: o_clk_en=1 each cycle. On i_ser_done: next cycle o_clk_en=0, state GAP, gap counter loaded GAP_CYCLES. o_ch_sel stable throughout.
- GAP: gap counter decrements to 0. Leave to IDLE on the cycle after counter==0 and i_packet_finished==0; otherwise stay in GAP. With GAP_CYCLES=0, exit on the first GAP cycle with i_packet_finished low.
- Latency:
  - IDLE request to o_read_enable: 1 cycle.
  - Ack to o_clk_en: 1 cycle.
  - i_ser_done to o_clk_en low: 1 cycle.
  - End of GAP to next grant: 2 cycles (GAP->IDLE->FETCH).
- Invariants:
  - o_read_enable is at most one-hot.
  - o_read_enable and o_clk_en are never both 1.
  - o_clk_en is 1 only in SENDING.
- i_empty of the granted channel changing after grant does not affect the current packet.
- i_ser_done outside SENDING is ignored.
- N_CH=1: arbitration degenerates, o_ch_sel=0 constant.

Test Plan:
1. N_CH=4, only ch2 non-empty, ack 3 cycles after read enable, i_ser_done 10 cycles later -> o_read_enable=4'b0100 for 3 cycles, o_ch_sel=2, o_clk_en high 10 cycles, GAP 2 cycles, back to IDLE.
2. All four channels permanently non-empty -> grants in order 0,1,2,3,0; no channel granted twice before the others.
3. Ack with i_dont_send_zeros=1 on ch1 -> o_clk_en never rises, o_drop_cnt 0->1, next grant to ch2. Repeat 300 drops with CNT_W=8 -> counter stays at 255.
4. No ack for TIMEOUT=16 cycles -> o_read_enable drops after 16 cycles, o_timeout_err pulses exactly 1 cycle, FSM returns to IDLE. Ack at cycle 16 -> SENDING, no error.
5. i_packet_finished held high 5 cycles past gap expiry -> FSM stays in GAP until it falls, then grants 2 cycles later. GAP_CYCLES=0 variant exits on the first GAP cycle.
6. Assert i_rst_n=0 during SENDING and during FETCH -> all outputs 0 immediately. After release, first grant goes to the lowest non-empty channel from pointer 0.
